// File: rtl/sipo_deser_pkg.sv
// Shared serial-link definitions used by the SIPO deserializer and the PISO shifter.
package sipo_deser_pkg;

    localparam int SER_WIDTH_DEFAULT = 4;

    localparam int SER_MSB_FIRST = 1;
    localparam int SER_LSB_FIRST = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserializer: collects WIDTH strobed bits into a word
// and presents it on p_out with a one-cycle p_valid pulse.
//
// state | meaning
// IDLE  | no partial word held, bit_cnt = 0
// SHIFT | partial word of 1..WIDTH-1 bits held
module sipo_deser
    import sipo_deser_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH_DEFAULT,
    parameter int MSB_FIRST = SER_MSB_FIRST
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_in,
    input  logic                     s_valid,
    input  logic                     clear,
    output logic [WIDTH-1:0]         p_out,
    output logic                     p_valid,
    output logic                     busy,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int CNT_W = $clog2(WIDTH);

    ser_state_t       state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_next;

    // Shift register contents after accepting s_in, in the configured bit order.
    always_comb begin
        sreg_next = sreg;
        if (MSB_FIRST == SER_MSB_FIRST) begin
            sreg_next = {sreg[WIDTH-2:0], s_in};
        end else begin
            sreg_next = {s_in, sreg[WIDTH-1:1]};
        end
    end

    // Word-assembly FSM; clear drops the partial word but never touches p_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sreg    <= '0;
            p_out   <= '0;
            p_valid <= 1'b0;
            busy    <= 1'b0;
            bit_cnt <= '0;
        end else begin
            p_valid <= 1'b0;
            if (clear) begin
                state   <= IDLE;
                sreg    <= '0;
                busy    <= 1'b0;
                bit_cnt <= '0;
            end else if (s_valid) begin
                sreg <= sreg_next;
                if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                    // The completing bit is taken from sreg_next so p_out includes it.
                    p_out   <= sreg_next;
                    p_valid <= 1'b1;
                    state   <= IDLE;
                    busy    <= 1'b0;
                    bit_cnt <= '0;
                end else begin
                    state   <= SHIFT;
                    busy    <= 1'b1;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end else begin
                state <= state;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench: two instances (MSB-first and LSB-first) share one stimulus
// stream and are compared every cycle against a queue-based word model.
module tb_sipo_deser;
    import sipo_deser_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic s_in = 1'b0;
    logic s_valid = 1'b0;
    logic clear = 1'b0;

    logic [W-1:0]         p_out_m, p_out_l;
    logic                 p_valid_m, p_valid_l;
    logic                 busy_m, busy_l;
    logic [$clog2(W)-1:0] bit_cnt_m, bit_cnt_l;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: bits of the current word in arrival order plus last words.
    logic       bits[$];
    logic [W-1:0] exp_m = '0;
    logic [W-1:0] exp_l = '0;
    logic       exp_valid = 1'b0;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(W), .MSB_FIRST(SER_MSB_FIRST)) dut_m (
        .clk(clk), .rst(rst), .s_in(s_in), .s_valid(s_valid), .clear(clear),
        .p_out(p_out_m), .p_valid(p_valid_m), .busy(busy_m), .bit_cnt(bit_cnt_m)
    );

    sipo_deser #(.WIDTH(W), .MSB_FIRST(SER_LSB_FIRST)) dut_l (
        .clk(clk), .rst(rst), .s_in(s_in), .s_valid(s_valid), .clear(clear),
        .p_out(p_out_l), .p_valid(p_valid_l), .busy(busy_l), .bit_cnt(bit_cnt_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic c, input logic v, input logic d);
        exp_valid = 1'b0;
        if (r) begin
            bits.delete();
            exp_m = '0;
            exp_l = '0;
        end else if (c) begin
            bits.delete();
        end else if (v) begin
            bits.push_back(d);
            if (bits.size() == W) begin
                for (int i = 0; i < W; i++) begin
                    exp_m[W-1-i] = bits[i];
                    exp_l[i]     = bits[i];
                end
                exp_valid = 1'b1;
                bits.delete();
            end
        end
    endtask

    task automatic check_all();
        chk("p_out_msb",   32'(p_out_m),   32'(exp_m));
        chk("p_valid_msb", 32'(p_valid_m), 32'(exp_valid));
        chk("busy_msb",    32'(busy_m),    32'(bits.size() != 0));
        chk("bit_cnt_msb", 32'(bit_cnt_m), 32'(bits.size()));
        chk("p_out_lsb",   32'(p_out_l),   32'(exp_l));
        chk("p_valid_lsb", 32'(p_valid_l), 32'(exp_valid));
        chk("busy_lsb",    32'(busy_l),    32'(bits.size() != 0));
        chk("bit_cnt_lsb", 32'(bit_cnt_l), 32'(bits.size()));
    endtask

    task automatic step(input logic r, input logic c, input logic v, input logic d);
        rst = r; clear = c; s_valid = v; s_in = d;
        @(posedge clk);
        model_update(r, c, v, d);
        #1;
        check_all();
    endtask

    task automatic send(input logic [W-1:0] word, input int gap);
        for (int i = W - 1; i >= 0; i--) begin
            step(1'b0, 1'b0, 1'b1, word[i]);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [W-1:0] saved;

        // Reset
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_p_out", 32'(p_out_m), 32'h0);

        // Basic word, back-to-back strobes, then idle cycle to see the pulse drop
        send(4'b1011, 0);
        chk("t1_word_msb", 32'(p_out_m), 32'hB);
        chk("t6_word_lsb", 32'(p_out_l), 32'hD);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Gaps between strobes
        send(4'b1011, 2);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Continuous streaming of two words
        send(4'b1011, 0);
        send(4'b0110, 0);
        chk("t3_second_word", 32'(p_out_m), 32'h6);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Clear mid-word together with a strobe: bit dropped, p_out kept
        saved = p_out_m;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("t4_hold_after_clear", 32'(p_out_m), 32'(saved));
        send(4'b0110, 0);
        chk("t4_next_word", 32'(p_out_m), 32'h6);

        // Clear in IDLE is a no-op
        step(1'b0, 1'b1, 1'b0, 1'b0);

        // Reset mid-word
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("t5_reset_busy", 32'(busy_m), 32'h0);
        send(4'b0001, 0);
        chk("t5_word", 32'(p_out_m), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 9) < 7),
                 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
